mac_vector_feeder: RTL and testbench

Sequencer that drives the streaming floating-point multiply-accumulate unit from its issuing side and collects its final sum. The host loads two single-precision operand vectors into local buffers, then pulses `start` with a length. The block streams one element pair per cycle into the MAC, flags the first element so the accumulator restarts, counts returning `mac_ovalid` beats, and latches the dot-product result.

---
 rtl/mac_feeder_pkg.sv | 18 +
 rtl/mac_operand_ram.sv | 29 ++
 rtl/mac_vector_feeder.sv | 132 +++++++++++++
 tb/tb_mac_vector_feeder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_feeder_pkg.sv
// Shared types and constants for the MAC vector feeder.
package mac_feeder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } feeder_state_t;

   // Pipeline depth of the streaming FP multiply-accumulate unit the feeder pairs with.
   localparam int MAC_LATENCY_DEFAULT = 7;

   // IEEE-754 single-precision constants.
   localparam logic [31:0] FP32_ONE = 32'h3F80_0000;
   localparam logic [31:0] FP32_TWO = 32'h4000_0000;

endpackage

// File: rtl/mac_operand_ram.sv
// Simple dual-port operand buffer: one write port, one read port with a registered output.
module mac_operand_ram #(
   parameter int AW = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [31:0]   wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [31:0]   rd_data
);

   logic [31:0] mem [2**AW];

   // Host write port.
   // NOTE: the storage array has no reset so it maps onto block RAM; contents survive a reset.
   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Registered read port; only the output register is cleared by reset.
   always_ff @(posedge clock) begin
      if (reset)      rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/mac_vector_feeder.sv
// Streams two operand vectors into a floating-point MAC and captures the final dot product.
module mac_vector_feeder
   import mac_feeder_pkg::*;
#(
   parameter int AW          = 8,
   parameter int MAC_LATENCY = MAC_LATENCY_DEFAULT
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          wr_en,
   input  logic          wr_sel,
   input  logic [AW-1:0] wr_addr,
   input  logic [31:0]   wr_data,
   input  logic          start,
   input  logic [AW:0]   len,
   output logic          busy,
   output logic          done,
   output logic [31:0]   result,
   output logic          err,
   output logic          mac_ivalid,
   output logic          mac_control,
   output logic [31:0]   mac_datainA,
   output logic [31:0]   mac_datainB,
   input  logic          mac_ovalid,
   input  logic [31:0]   mac_dataout
);

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   feeder_state_t state;
   logic [AW:0]   len_q;
   logic [AW:0]   issue_cnt;
   logic [AW:0]   ret_cnt;
   logic          active;
   logic          len_ok;
   logic          issue_last;
   logic          beat_last;
   logic          buf_we;
   logic          rd_en;

   // Completion is detected by counting returned beats, so the latency value is
   // carried only to document which MAC this feeder is paired with.
   logic [31:0] lat_unused;
   assign lat_unused = 32'(MAC_LATENCY);

   // Per-cycle decode of the FSM and counters.
   // NOTE: combinational logic uses blocking '=' and assigns every signal on every
   // path, so no latch can form; registered state further down uses '<=' only.
   always_comb begin
      active     = (state == ISSUE) || (state == DRAIN);
      len_ok     = (len != '0) && (len <= DEPTH);
      issue_last = (issue_cnt == len_q - 1'b1);
      beat_last  = mac_ovalid && (ret_cnt == len_q - 1'b1);
      buf_we     = wr_en && !active;
      rd_en      = (state == ISSUE);
   end

   mac_operand_ram #(.AW(AW)) u_ram_a (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (buf_we && !wr_sel),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (issue_cnt[AW-1:0]),
      .rd_data (mac_datainA)
   );

   mac_operand_ram #(.AW(AW)) u_ram_b (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (buf_we && wr_sel),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (issue_cnt[AW-1:0]),
      .rd_data (mac_datainB)
   );

   // Sequencer FSM with counters and registered outputs; mac_* strobes trail the read address by one cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         len_q       <= '0;
         issue_cnt   <= '0;
         ret_cnt     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         result      <= '0;
         mac_ivalid  <= 1'b0;
         mac_control <= 1'b0;
      end else begin
         done        <= 1'b0;
         err         <= active && (start || wr_en);
         mac_ivalid  <= (state == ISSUE);
         mac_control <= (state == ISSUE) && (issue_cnt == '0);
         if (active && mac_ovalid) ret_cnt <= ret_cnt + 1'b1;

         unique case (state)
            IDLE: begin
               if (start) begin
                  if (len_ok) begin
                     len_q     <= len;
                     issue_cnt <= '0;
                     ret_cnt   <= '0;
                     busy      <= 1'b1;
                     state     <= ISSUE;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               issue_cnt <= issue_cnt + 1'b1;
               if (issue_last) state <= DRAIN;
            end
            DRAIN: begin
               if (beat_last) begin
                  result <= mac_dataout;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_vector_feeder.sv
// Self-checking bench: behavioural MAC, buffer scoreboard and cycle-accurate run checks.
module tb_mac_vector_feeder;
   import mac_feeder_pkg::*;

   localparam int AW    = 8;
   localparam int DEPTH = 2**AW;
   localparam int LAT   = MAC_LATENCY_DEFAULT;

   logic          clock = 1'b0;
   logic          reset;
   logic          wr_en;
   logic          wr_sel;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_data;
   logic          start;
   logic [AW:0]   len;
   logic          busy;
   logic          done;
   logic [31:0]   result;
   logic          err;
   logic          mac_ivalid;
   logic          mac_control;
   logic [31:0]   mac_datainA;
   logic [31:0]   mac_datainB;
   logic          mac_ovalid;
   logic [31:0]   mac_dataout;

   int n_checks = 0;
   int n_pass   = 0;
   int ref_a [DEPTH];
   int ref_b [DEPTH];

   always #5 clock = ~clock;

   mac_vector_feeder #(.AW(AW), .MAC_LATENCY(LAT)) dut (
      .clock       (clock),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_sel      (wr_sel),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .start       (start),
      .len         (len),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .err         (err),
      .mac_ivalid  (mac_ivalid),
      .mac_control (mac_control),
      .mac_datainA (mac_datainA),
      .mac_datainB (mac_datainB),
      .mac_ovalid  (mac_ovalid),
      .mac_dataout (mac_dataout)
   );

   // Integer-valued floats only (0 .. 2^24), which keeps every sum exact.
   function automatic logic [31:0] int_to_f32(input int v);
      int          p;
      logic [31:0] m;
      if (v == 0) return 32'h0;
      p = 0;
      for (int i = 0; i < 31; i++) if (v[i]) p = i;
      m = 32'(v) << (23 - p);
      return {1'b0, 8'(127 + p), m[22:0]};
   endfunction

   function automatic int f32_to_int(input logic [31:0] f);
      int          p;
      logic [31:0] m;
      if (f[30:0] == 31'h0) return 0;
      p = int'(f[30:23]) - 127;
      m = {8'h0, 1'b1, f[22:0]};
      return int'(m >> (23 - p));
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   // Behavioural MAC: fixed latency, accumulator restarts on mac_control.
   logic        pipe_v [LAT];
   logic [31:0] pipe_d [LAT];
   int          mac_acc = 0;

   initial begin
      for (int i = 0; i < LAT; i++) begin
         pipe_v[i] = 1'b0;
         pipe_d[i] = 32'h0;
      end
   end

   always @(posedge clock) begin : mac_model
      int prod;
      if (mac_ivalid === 1'b1) begin
         prod    = f32_to_int(mac_datainA) * f32_to_int(mac_datainB);
         mac_acc = (mac_control === 1'b1) ? prod : mac_acc + prod;
      end
      pipe_v[0] <= (mac_ivalid === 1'b1);
      pipe_d[0] <= int_to_f32(mac_acc);
      for (int i = 1; i < LAT; i++) begin
         pipe_v[i] <= pipe_v[i-1];
         pipe_d[i] <= pipe_d[i-1];
      end
   end

   assign mac_ovalid  = pipe_v[LAT-1];
   assign mac_dataout = pipe_d[LAT-1];

   // All tasks start and end at a falling edge.
   task automatic write_word(input logic sel, input int addr, input int val);
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_addr = AW'(addr);
      wr_data = int_to_f32(val);
      if (sel) ref_b[addr] = val;
      else     ref_a[addr] = val;
      @(negedge clock);
      wr_en = 1'b0;
   endtask

   // One dot product; optional write/start injected at cycle offsets (0 = none).
   task automatic run_dot(input string tag, input int n, input int inj_wr_k, input int inj_start_k);
      int          exp_sum = 0;
      int          done_k  = 0;
      int          bad_iv  = 0;
      int          bad_ctl = 0;
      int          bad_bsy = 0;
      int          bad_err = 0;
      logic [31:0] res_at_done = 32'hDEAD_BEEF;
      for (int i = 0; i < n; i++) exp_sum += ref_a[i] * ref_b[i];
      @(negedge clock);
      start = 1'b1;
      len   = (AW+1)'(n);
      for (int k = 1; k <= n + LAT + 20; k++) begin
         @(negedge clock);
         start = 1'b0;
         wr_en = 1'b0;
         if (mac_ivalid  !== ((k >= 2) && (k <= n + 1)))      bad_iv++;
         if (mac_control !== (k == 2))                         bad_ctl++;
         if (busy        !== ((k >= 1) && (k <= n + LAT + 1))) bad_bsy++;
         if (err !== (((inj_wr_k > 0) && (k == inj_wr_k + 1)) ||
                      ((inj_start_k > 0) && (k == inj_start_k + 1)))) bad_err++;
         if (done === 1'b1) begin
            done_k      = k;
            res_at_done = result;
            break;
         end
         if (k == inj_wr_k) begin
            wr_en   = 1'b1;
            wr_sel  = 1'b0;
            wr_addr = '0;
            wr_data = int_to_f32(99);
         end
         if (k == inj_start_k) begin
            start = 1'b1;
            len   = (AW+1)'($urandom_range(0, 2*DEPTH - 1));
         end
      end
      check({tag, "_done_cycle"}, done_k, n + LAT + 2);
      check({tag, "_result"}, res_at_done, int_to_f32(exp_sum));
      check({tag, "_ivalid_errs"}, bad_iv, 0);
      check({tag, "_control_errs"}, bad_ctl, 0);
      check({tag, "_busy_errs"}, bad_bsy, 0);
      check({tag, "_err_errs"}, bad_err, 0);
   endtask

   task automatic illegal_start(input string tag, input int n);
      int bad_err = 0;
      int n_busy  = 0;
      int n_iv    = 0;
      @(negedge clock);
      start = 1'b1;
      len   = (AW+1)'(n);
      for (int k = 1; k <= 15; k++) begin
         @(negedge clock);
         start = 1'b0;
         if (err !== (k == 1)) bad_err++;
         if (busy === 1'b1) n_busy++;
         if (mac_ivalid === 1'b1) n_iv++;
      end
      check({tag, "_err_errs"}, bad_err, 0);
      check({tag, "_busy_cycles"}, n_busy, 0);
      check({tag, "_ivalid_cycles"}, n_iv, 0);
   endtask

   task automatic load_ramp_ones(input int n);
      for (int i = 0; i < n; i++) write_word(1'b0, i, i + 1);
      for (int i = 0; i < n; i++) write_word(1'b1, i, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_sel  = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      start   = 1'b0;
      len     = '0;
      repeat (3) @(negedge clock);

      check("rst_busy",        busy,        1'b0);
      check("rst_done",        done,        1'b0);
      check("rst_err",         err,         1'b0);
      check("rst_mac_ivalid",  mac_ivalid,  1'b0);
      check("rst_mac_control", mac_control, 1'b0);
      check("rst_result",      result,      32'h0);
      check("rst_datainA",     mac_datainA, 32'h0);
      check("rst_datainB",     mac_datainB, 32'h0);
      reset = 1'b0;
      @(negedge clock);

      // A=[1,2,3,4], B=ones -> 10.0
      load_ramp_ones(4);
      run_dot("ramp4", 4, 0, 0);
      check("ramp4_const", result, 32'h4120_0000);

      // Single element 2.0*2.0 -> 4.0
      write_word(1'b0, 0, 2);
      write_word(1'b1, 0, 2);
      run_dot("single", 1, 0, 0);
      check("single_const", result, 32'h4080_0000);

      // Back-to-back runs over all-ones: 4.0 then 2.0 (accumulator restarts)
      for (int i = 0; i < 4; i++) begin
         write_word(1'b0, i, 1);
         write_word(1'b1, i, 1);
      end
      run_dot("b2b_first", 4, 0, 0);
      run_dot("b2b_second", 2, 0, 0);
      check("b2b_second_const", result, FP32_TWO);

      // Illegal lengths
      illegal_start("len_zero", 0);
      illegal_start("len_over", DEPTH + 1);
      check("illegal_result_held", result, FP32_TWO);

      // Write and start while issuing: both rejected, result unaffected
      load_ramp_ones(4);
      run_dot("inject", 4, 2, 3);
      check("inject_const", result, 32'h4120_0000);
      run_dot("inject_after", 4, 0, 0);
      check("inject_after_const", result, 32'h4120_0000);

      // Reset in the middle of a len=8 run
      load_ramp_ones(8);
      begin
         int bad_iv  = 0;
         int bad_bsy = 0;
         int n_done  = 0;
         int n_err   = 0;
         logic [31:0] da_after = 32'hFFFF_FFFF;
         @(negedge clock);
         start = 1'b1;
         len   = (AW+1)'(8);
         for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (mac_ivalid !== ((k >= 2) && (k <= 4))) bad_iv++;
            if (busy !== ((k >= 1) && (k <= 4)))       bad_bsy++;
            if (done === 1'b1) n_done++;
            if (err === 1'b1)  n_err++;
            if (k == 5) begin
               da_after = mac_datainA;
               reset    = 1'b0;
            end
            if (k == 4) reset = 1'b1;
         end
         check("midreset_ivalid_errs", bad_iv, 0);
         check("midreset_busy_errs", bad_bsy, 0);
         check("midreset_done_count", n_done, 0);
         check("midreset_err_count", n_err, 0);
         check("midreset_datainA", da_after, 32'h0);
      end
      run_dot("post_reset", 4, 0, 0);
      check("post_reset_const", result, 32'h4120_0000);

      // Full depth, all ones -> 256.0, then a short run starting at address 0 again
      for (int i = 0; i < DEPTH; i++) begin
         write_word(1'b0, i, 1);
         write_word(1'b1, i, 1);
      end
      run_dot("full_depth", DEPTH, 0, 0);
      check("full_depth_const", result, 32'h4380_0000);
      for (int i = 0; i < 4; i++) write_word(1'b0, i, i + 1);
      run_dot("wrap", 4, 0, 0);
      check("wrap_const", result, 32'h4120_0000);

      // Randomised lengths and small-integer operands
      for (int r = 0; r < 8; r++) begin
         int n;
         n = $urandom_range(1, 24);
         for (int i = 0; i < n; i++) begin
            write_word(1'b0, i, $urandom_range(0, 9));
            write_word(1'b1, i, $urandom_range(0, 9));
         end
         run_dot($sformatf("rand%0d", r), n, 0, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
